// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: BUF_DEPTH-entry in-order retire queue that retires at most one
// instruction per cycle, with flush handling, TLB random index LCG and retired-instruction counter.
module wb_retire_unit #(
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned EXC_NUM   = 16,
  parameter int unsigned TLBIDX_W  = 4,
  parameter int unsigned CNT_W     = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic                       in_gr_we,
  input  logic [4:0]                 in_dest,
  input  logic [31:0]                in_result,
  input  logic [EXC_NUM-1:0]         in_exc_flgs,
  input  logic                       in_ertn,
  input  logic                       in_refetch,
  input  logic [78:0]                in_csr,
  input  logic [3:0]                 in_tlb_op,
  input  logic [TLBIDX_W:0]          in_tlbsrch,
  input  logic                       retire_stall,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic                       csr_we,
  output logic [13:0]                csr_wnum,
  output logic [31:0]                csr_wmask,
  output logic [31:0]                csr_wval,
  output logic                       wb_exc,
  output logic [$clog2(EXC_NUM)-1:0] wb_exc_idx,
  output logic [31:0]                wb_pc,
  output logic [31:0]                wb_badvaddr,
  output logic                       ertn_flush,
  output logic                       refetch_flush,
  output logic                       tlb_srch_we,
  output logic                       tlb_rd_we,
  output logic                       tlb_wr_we,
  output logic                       tlb_fill_we,
  output logic                       tlbsrch_hit,
  output logic [TLBIDX_W-1:0]        tlbsrch_hit_index,
  output logic [TLBIDX_W-1:0]        tlb_w_index,
  input  logic [TLBIDX_W-1:0]        csr_tlbidx_index,
  output logic [15:0]                csr_blk,
  output logic [CNT_W-1:0]           retired_cnt,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  localparam int unsigned PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_Q_W   = $clog2(BUF_DEPTH + 1);
  localparam int unsigned EXC_IDX_W = $clog2(EXC_NUM);

  typedef struct packed {
    logic [31:0]         pc;
    logic                gr_we;
    logic [4:0]          dest;
    logic [31:0]         result;
    logic [EXC_NUM-1:0]  exc_flgs;
    logic                ertn;
    logic                refetch;
    logic [78:0]         csr;
    logic [3:0]          tlb_op;
    logic [TLBIDX_W:0]   tlbsrch;
  } entry_t;

  entry_t               mem [BUF_DEPTH];
  entry_t               hd;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_Q_W-1:0]   count;
  logic [BUF_DEPTH-1:0] valid;
  logic [TLBIDX_W-1:0]  rnd;

  logic head_valid;
  logic retire;
  logic exc;
  logic push;
  logic flush;
  logic any_csr_we;
  logic any_ertn;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign hd         = mem[head];
  assign head_valid = (count != '0);
  // Reset suppresses retirement so a mid-operation reset produces no partial strobes.
  assign retire     = head_valid & ~retire_stall & ~reset;
  assign exc        = retire & (|hd.exc_flgs);
  assign in_ready   = (count < CNT_Q_W'(BUF_DEPTH)) | retire;
  assign push       = in_valid & in_ready;
  assign flush      = exc | ertn_flush | refetch_flush;

  assign rf_we         = retire & hd.gr_we & ~exc & ~hd.ertn;
  assign rf_waddr      = hd.dest;
  assign rf_wdata      = hd.result;
  assign csr_we        = retire & hd.csr[78] & ~exc;
  assign csr_wnum      = hd.csr[77:64];
  assign csr_wmask     = hd.csr[63:32];
  assign csr_wval      = hd.csr[31:0];
  assign wb_exc        = exc;
  assign wb_pc         = hd.pc;
  assign wb_badvaddr   = hd.result;
  assign ertn_flush    = retire & hd.ertn & ~exc;
  assign refetch_flush = retire & hd.refetch & ~exc;

  assign tlb_srch_we       = retire & hd.tlb_op[3] & ~exc;
  assign tlb_rd_we         = retire & hd.tlb_op[2] & ~exc;
  assign tlb_wr_we         = retire & hd.tlb_op[1] & ~exc;
  assign tlb_fill_we       = retire & hd.tlb_op[0] & ~exc;
  assign tlbsrch_hit       = hd.tlbsrch[TLBIDX_W];
  assign tlbsrch_hit_index = hd.tlbsrch[TLBIDX_W-1:0];
  assign tlb_w_index       = (head_valid & hd.tlb_op[1]) ? csr_tlbidx_index : rnd;

  assign csr_blk = {any_csr_we, any_ertn, head_valid ? hd.csr[77:64] : 14'h0};

  assign debug_wb_pc       = hd.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = hd.dest;
  assign debug_wb_rf_wdata = hd.result;

  // Lowest set flag wins.
  always_comb begin
    wb_exc_idx = '0;
    for (int i = EXC_NUM - 1; i >= 0; i--) begin
      if (hd.exc_flgs[i]) wb_exc_idx = EXC_IDX_W'(i);
    end
  end

  always_comb begin
    any_csr_we = 1'b0;
    any_ertn   = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      any_csr_we = any_csr_we | (valid[i] & mem[i].csr[78]);
      any_ertn   = any_ertn   | (valid[i] & mem[i].ertn);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{pc: in_pc, gr_we: in_gr_we, dest: in_dest, result: in_result,
                     exc_flgs: in_exc_flgs, ertn: in_ertn, refetch: in_refetch,
                     csr: in_csr, tlb_op: in_tlb_op, tlbsrch: in_tlbsrch};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      valid       <= '0;
      rnd         <= TLBIDX_W'(1);
      retired_cnt <= '0;
    end else begin
      rnd <= rnd * TLBIDX_W'(5) + TLBIDX_W'(13);
      if (retire & ~exc) retired_cnt <= retired_cnt + CNT_W'(1);
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        valid <= '0;
      end else begin
        // Clear before set: on push-while-full the retiring slot is the one being refilled.
        if (retire) begin
          head        <= ptr_inc(head);
          valid[head] <= 1'b0;
        end
        if (push) begin
          tail        <= ptr_inc(tail);
          valid[tail] <= 1'b1;
        end
        count <= count + CNT_Q_W'(push) - CNT_Q_W'(retire);
      end
    end
  end

endmodule

// File: tb/tb_wb_retire_unit.sv
// Directed, table-driven bench for wb_retire_unit (default parameters), plus hand sequences
// for reset mid-operation and the TLB random index sequence.
module tb_wb_retire_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic        in_gr_we;
  logic [4:0]  in_dest;
  logic [31:0] in_result;
  logic [15:0] in_exc_flgs;
  logic        in_ertn;
  logic        in_refetch;
  logic [78:0] in_csr;
  logic [3:0]  in_tlb_op;
  logic [4:0]  in_tlbsrch;
  logic        retire_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        csr_we;
  logic [13:0] csr_wnum;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wval;
  logic        wb_exc;
  logic [3:0]  wb_exc_idx;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        ertn_flush;
  logic        refetch_flush;
  logic        tlb_srch_we;
  logic        tlb_rd_we;
  logic        tlb_wr_we;
  logic        tlb_fill_we;
  logic        tlbsrch_hit;
  logic [3:0]  tlbsrch_hit_index;
  logic [3:0]  tlb_w_index;
  logic [3:0]  csr_tlbidx_index;
  logic [15:0] csr_blk;
  logic [63:0] retired_cnt;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  always #5 clk = ~clk;

  wb_retire_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_gr_we(in_gr_we), .in_dest(in_dest), .in_result(in_result), .in_exc_flgs(in_exc_flgs),
    .in_ertn(in_ertn), .in_refetch(in_refetch), .in_csr(in_csr), .in_tlb_op(in_tlb_op),
    .in_tlbsrch(in_tlbsrch), .retire_stall(retire_stall), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .csr_we(csr_we), .csr_wnum(csr_wnum), .csr_wmask(csr_wmask),
    .csr_wval(csr_wval), .wb_exc(wb_exc), .wb_exc_idx(wb_exc_idx), .wb_pc(wb_pc),
    .wb_badvaddr(wb_badvaddr), .ertn_flush(ertn_flush), .refetch_flush(refetch_flush),
    .tlb_srch_we(tlb_srch_we), .tlb_rd_we(tlb_rd_we), .tlb_wr_we(tlb_wr_we),
    .tlb_fill_we(tlb_fill_we), .tlbsrch_hit(tlbsrch_hit), .tlbsrch_hit_index(tlbsrch_hit_index),
    .tlb_w_index(tlb_w_index), .csr_tlbidx_index(csr_tlbidx_index), .csr_blk(csr_blk),
    .retired_cnt(retired_cnt), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct {
    logic        v;
    logic        stall;
    logic        gr_we;
    logic [4:0]  dest;
    logic [15:0] exc;
    logic        ertn;
    logic        refetch;
    logic        csr_we;
    logic [3:0]  tlb_op;
    logic [3:0]  csr_idx;
    logic        e_ready;
    logic        e_rf_we;
    logic [4:0]  e_waddr;
    logic        e_csr_we;
    logic        e_exc;
    logic [3:0]  e_exc_idx;
    logic        e_ertn;
    logic        e_refetch;
    logic        e_fill;
    logic        e_wr;
    logic        chk_widx;
    logic [3:0]  e_widx;
    logic [63:0] e_cnt;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];
  int checks = 0;
  int errors = 0;

  function automatic vec_t base(input logic v, input logic stall, input logic gr,
                                input logic [4:0] dest, input logic rdy, input logic rfwe,
                                input logic [4:0] waddr, input logic [63:0] cnt);
    vec_t r;
    r = '{default: '0};
    r.v = v; r.stall = stall; r.gr_we = gr; r.dest = dest;
    r.e_ready = rdy; r.e_rf_we = rfwe; r.e_waddr = waddr; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid         = v.v;
    retire_stall     = v.stall;
    in_pc            = 32'h1000 + 32'(v.dest);
    in_gr_we         = v.gr_we;
    in_dest          = v.dest;
    in_result        = 32'h100 + 32'(v.dest);
    in_exc_flgs      = v.exc;
    in_ertn          = v.ertn;
    in_refetch       = v.refetch;
    in_csr           = {v.csr_we, 14'(v.dest), 32'hFFFF_FFFF, 32'h200 + 32'(v.dest)};
    in_tlb_op        = v.tlb_op;
    in_tlbsrch       = 5'h0;
    csr_tlbidx_index = v.csr_idx;
  endtask

  task automatic check_row(input string tag, input vec_t v);
    chk({tag, " in_ready"}, 64'(in_ready), 64'(v.e_ready));
    chk({tag, " rf_we"}, 64'(rf_we), 64'(v.e_rf_we));
    chk({tag, " dbg_wen"}, 64'(debug_wb_rf_wen), 64'({4{v.e_rf_we}}));
    chk({tag, " csr_we"}, 64'(csr_we), 64'(v.e_csr_we));
    chk({tag, " wb_exc"}, 64'(wb_exc), 64'(v.e_exc));
    chk({tag, " ertn_flush"}, 64'(ertn_flush), 64'(v.e_ertn));
    chk({tag, " refetch_flush"}, 64'(refetch_flush), 64'(v.e_refetch));
    chk({tag, " tlb_fill_we"}, 64'(tlb_fill_we), 64'(v.e_fill));
    chk({tag, " tlb_wr_we"}, 64'(tlb_wr_we), 64'(v.e_wr));
    chk({tag, " retired_cnt"}, retired_cnt, v.e_cnt);
    if (v.e_rf_we) begin
      chk({tag, " rf_waddr"}, 64'(rf_waddr), 64'(v.e_waddr));
      chk({tag, " rf_wdata"}, 64'(rf_wdata), 64'(32'h100 + 32'(v.e_waddr)));
    end
    if (v.e_csr_we) chk({tag, " csr_wnum"}, 64'(csr_wnum), 64'(v.e_waddr));
    if (v.e_exc) chk({tag, " wb_exc_idx"}, 64'(wb_exc_idx), 64'(v.e_exc_idx));
    if (v.chk_widx) chk({tag, " tlb_w_index"}, 64'(tlb_w_index), 64'(v.e_widx));
  endtask

  initial begin
    // Main stream; row i is cycle i after reset release.
    tbl[0]  = base(1, 0, 1, 1,  1, 0, 0,  0); tbl[0].chk_widx = 1; tbl[0].e_widx = 4'd1;
    tbl[1]  = base(1, 0, 1, 2,  1, 1, 1,  0);
    tbl[2]  = base(1, 0, 1, 3,  1, 1, 2,  1);
    tbl[3]  = base(0, 0, 0, 0,  1, 1, 3,  2);
    tbl[4]  = base(0, 0, 0, 0,  1, 0, 0,  3);
    tbl[5]  = base(1, 1, 1, 4,  1, 0, 0,  3);
    tbl[6]  = base(1, 1, 1, 5,  1, 0, 0,  3);
    tbl[7]  = base(1, 1, 1, 6,  0, 0, 0,  3);
    tbl[8]  = base(1, 0, 1, 6,  1, 1, 4,  3);
    tbl[9]  = base(0, 0, 0, 0,  1, 1, 5,  4);
    tbl[10] = base(0, 0, 0, 0,  1, 1, 6,  5);
    tbl[11] = base(0, 0, 0, 0,  1, 0, 0,  6);
    tbl[12] = base(1, 1, 1, 7,  1, 0, 0,  6); tbl[12].exc = 16'h0012; tbl[12].csr_we = 1;
    tbl[13] = base(1, 1, 1, 8,  1, 0, 0,  6);
    tbl[14] = base(1, 0, 1, 9,  1, 0, 0,  6); tbl[14].e_exc = 1; tbl[14].e_exc_idx = 4'd1;
    tbl[15] = base(0, 0, 0, 0,  1, 0, 0,  6);
    tbl[16] = base(1, 1, 1, 10, 1, 0, 0,  6); tbl[16].ertn = 1; tbl[16].csr_we = 1;
    tbl[17] = base(1, 1, 1, 11, 1, 0, 0,  6);
    tbl[18] = base(0, 0, 0, 0,  1, 0, 10, 6); tbl[18].e_ertn = 1; tbl[18].e_csr_we = 1;
    tbl[19] = base(0, 0, 0, 0,  1, 0, 0,  7);
    tbl[20] = base(1, 0, 1, 12, 1, 0, 0,  7); tbl[20].refetch = 1;
    tbl[21] = base(1, 0, 1, 13, 1, 1, 12, 7); tbl[21].e_refetch = 1;
    tbl[22] = base(0, 0, 0, 0,  1, 0, 0,  8);
    tbl[23] = base(1, 0, 0, 0,  1, 0, 0,  8); tbl[23].tlb_op = 4'b0001;
    tbl[24] = base(1, 0, 0, 0,  1, 0, 0,  8); tbl[24].tlb_op = 4'b0010;
    tbl[24].e_fill = 1; tbl[24].chk_widx = 1; tbl[24].e_widx = 4'd9;
    tbl[25] = base(0, 0, 0, 0,  1, 0, 0,  9); tbl[25].csr_idx = 4'hA;
    tbl[25].e_wr = 1; tbl[25].chk_widx = 1; tbl[25].e_widx = 4'hA;
    tbl[26] = base(0, 0, 0, 0,  1, 0, 0, 10);

    drive(base(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      #1;
      check_row($sformatf("row%0d", i), tbl[i]);
      @(negedge clk);
    end

    // Two entries queued under stall, then reset with stall still held.
    drive(base(1, 1, 1, 20, 0, 0, 0, 0));
    @(negedge clk);
    drive(base(1, 1, 1, 21, 0, 0, 0, 0));
    @(negedge clk);
    drive(base(0, 1, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    #1;
    chk("rst rf_we", 64'(rf_we), 64'd0);
    chk("rst csr_blk_any", 64'(csr_blk[15]), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // After reset: empty queue, counter cleared, then fills walk the LCG 1,2,7,0,13.
    for (int k = 0; k < 6; k++) begin
      vec_t v;
      logic [3:0] lcg [5];
      lcg[0] = 4'd1; lcg[1] = 4'd2; lcg[2] = 4'd7; lcg[3] = 4'd0; lcg[4] = 4'd13;
      v = base((k < 4) ? 1'b1 : 1'b0, 0, 0, 0, 1, 0, 0, (k == 0) ? 64'd0 : 64'(k - 1));
      v.tlb_op = (k < 4) ? 4'b0001 : 4'b0000;
      v.e_fill = (k >= 1 && k <= 4);
      v.chk_widx = (k <= 4);
      v.e_widx = (k <= 4) ? lcg[k] : 4'd0;
      drive(v);
      #1;
      check_row($sformatf("post_rst%0d", k), v);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
